// File: rtl/hazard_stall_unit_pkg.sv
// ============================================================================
// Module   : hazard_stall_unit_pkg
// Purpose  : Shared types and constants for the hazard/stall unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package hazard_stall_unit_pkg;

  localparam int REGW_DEF = 5;
  // Entries store register numbers at this width; REGW must not exceed it.
  localparam int REGW_MAX = 8;

  localparam logic [REGW_MAX-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic                valid;
    logic [REGW_MAX-1:0] wr_reg;
    logic                is_load;
  } sb_entry_t;

  localparam sb_entry_t SB_EMPTY = '0;

endpackage

`default_nettype wire

// File: rtl/hazard_stall_unit_if.sv
// ============================================================================
// Module   : hazard_stall_unit_if
// Purpose  : ID-stage information in, stall/bubble/counter out.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hazard_stall_unit_if #(
  parameter int REGW = hazard_stall_unit_pkg::REGW_DEF,
  parameter int CNTW = 16
);
  logic            id_valid;
  logic            id_r1_used;
  logic            id_r2_used;
  logic [REGW-1:0] id_rs;
  logic [REGW-1:0] id_rt;
  logic            id_wr_en;
  logic [REGW-1:0] id_wr_reg;
  logic            id_is_load;
  logic            flush;
  logic            stall;
  logic            bubble;
  logic [CNTW-1:0] stall_cnt;

  modport master (
    output id_valid, id_r1_used, id_r2_used, id_rs, id_rt,
           id_wr_en, id_wr_reg, id_is_load, flush,
    input  stall, bubble, stall_cnt
  );

  modport slave (
    input  id_valid, id_r1_used, id_r2_used, id_rs, id_rt,
           id_wr_en, id_wr_reg, id_is_load, flush,
    output stall, bubble, stall_cnt
  );
endinterface

`default_nettype wire

// File: rtl/hazard_match.sv
// ============================================================================
// Module   : hazard_match
// Purpose  : Source-register match of the ID instruction against one entry.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_match
  import hazard_stall_unit_pkg::*;
(
  input  logic                id_valid_i,
  input  logic                r1_used_i,
  input  logic                r2_used_i,
  input  logic [REGW_MAX-1:0] rs_i,
  input  logic [REGW_MAX-1:0] rt_i,
  input  sb_entry_t           ent_i,
  output logic                match_o,
  output logic                load_match_o
);

  logic w_rs_hit;
  logic w_rt_hit;

  assign w_rs_hit     = r1_used_i & (rs_i == ent_i.wr_reg);
  assign w_rt_hit     = r2_used_i & (rt_i == ent_i.wr_reg);
  assign match_o      = id_valid_i & ent_i.valid & (w_rs_hit | w_rt_hit);
  assign load_match_o = match_o & ent_i.is_load;

endmodule

`default_nettype wire

// File: rtl/hazard_stall_unit.sv
// ============================================================================
// Module   : hazard_stall_unit
// Purpose  : EX/MEM in-flight scoreboard producing stall, bubble and a
//            saturating stall counter. Macro HAZARD_FORWARD_EN limits
//            stalls to the load-use case (ALU results forwarded).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int REGW = REGW_DEF,
  parameter int CNTW = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hazard_stall_unit_if.slave   bus
);

  sb_entry_t           ex_q, ex_d;
  sb_entry_t           mem_q, mem_d;
  sb_entry_t           w_id_ent;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic [REGW_MAX-1:0] w_rs, w_rt;
  logic                w_ex_match, w_ex_ld;
  logic                w_mem_match, w_mem_ld;
  logic                w_hazard, w_stall, w_bubble;
  logic                unused_ok;

  assign w_rs = REGW_MAX'(bus.id_rs);
  assign w_rt = REGW_MAX'(bus.id_rt);

  // $0 is hard-wired, so writes to it never produce a dependency.
  always_comb begin
    w_id_ent         = SB_EMPTY;
    w_id_ent.wr_reg  = REGW_MAX'(bus.id_wr_reg);
    w_id_ent.is_load = bus.id_is_load;
    w_id_ent.valid   = bus.id_valid & bus.id_wr_en &
                       (REGW_MAX'(bus.id_wr_reg) != REG_ZERO);
  end

  hazard_match u_match_ex (
    .id_valid_i   (bus.id_valid),
    .r1_used_i    (bus.id_r1_used),
    .r2_used_i    (bus.id_r2_used),
    .rs_i         (w_rs),
    .rt_i         (w_rt),
    .ent_i        (ex_q),
    .match_o      (w_ex_match),
    .load_match_o (w_ex_ld)
  );

  hazard_match u_match_mem (
    .id_valid_i   (bus.id_valid),
    .r1_used_i    (bus.id_r1_used),
    .r2_used_i    (bus.id_r2_used),
    .rs_i         (w_rs),
    .rt_i         (w_rt),
    .ent_i        (mem_q),
    .match_o      (w_mem_match),
    .load_match_o (w_mem_ld)
  );

`ifdef HAZARD_FORWARD_EN
  assign w_hazard  = w_ex_ld;
  assign unused_ok = &{1'b0, w_ex_match, w_mem_match, w_mem_ld};
`else
  assign w_hazard  = w_ex_match | w_mem_match;
  assign unused_ok = &{1'b0, w_ex_ld, w_mem_ld};
`endif

  // A resolved branch kills the ID instruction, so its hazard is moot.
  assign w_stall  = w_hazard & ~bus.flush;
  assign w_bubble = w_stall | bus.flush;

  always_comb begin
    ex_d  = w_bubble ? SB_EMPTY : w_id_ent;
    mem_d = ex_q;
    cnt_d = cnt_q;
    if (w_stall && !(&cnt_q)) begin
      cnt_d = cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= SB_EMPTY;
      mem_q <= SB_EMPTY;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.stall     = w_stall;
  assign bus.bubble    = w_bubble;
  assign bus.stall_cnt = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_unit.sv
// ============================================================================
// Module   : tb_hazard_stall_unit
// Purpose  : Scoreboard bench for hazard_stall_unit; a second instance with a
//            4-bit counter exercises saturation. Honors HAZARD_FORWARD_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_stall_unit;

`ifdef HAZARD_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct {
    logic        stall;
    logic        bubble;
    logic [15:0] cnt;
    logic [3:0]  cnt4;
    string       tag;
  } exp_t;

  logic  clk;
  logic  rst_n;
  int    n_cmp;
  int    n_err;
  exp_t  exp_q[$];
  logic [15:0] exp_cnt;
  logic [3:0]  exp_cnt4;

  hazard_stall_unit_if #(.REGW(5), .CNTW(16)) if_main ();
  hazard_stall_unit_if #(.REGW(5), .CNTW(4))  if_sat  ();

  hazard_stall_unit #(.REGW(5), .CNTW(16)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_main)
  );

  hazard_stall_unit #(.REGW(5), .CNTW(4)) u_dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic r1u, input logic r2u,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic we, input logic [4:0] wr,
                       input logic ld, input logic fl);
    if_main.id_valid = v;   if_sat.id_valid = v;
    if_main.id_r1_used = r1u; if_sat.id_r1_used = r1u;
    if_main.id_r2_used = r2u; if_sat.id_r2_used = r2u;
    if_main.id_rs = rs;     if_sat.id_rs = rs;
    if_main.id_rt = rt;     if_sat.id_rt = rt;
    if_main.id_wr_en = we;  if_sat.id_wr_en = we;
    if_main.id_wr_reg = wr; if_sat.id_wr_reg = wr;
    if_main.id_is_load = ld; if_sat.id_is_load = ld;
    if_main.flush = fl;     if_sat.flush = fl;
  endtask

  task automatic add_i(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    drive(1'b1, 1'b1, 1'b1, rs, rt, 1'b1, rd, 1'b0, 1'b0);
  endtask

  // lw rt, off(rs): reads only the base register
  task automatic lw_i(input logic [4:0] rt, input logic [4:0] base);
    drive(1'b1, 1'b1, 1'b0, base, rt, 1'b1, rt, 1'b1, 1'b0);
  endtask

  task automatic idle_i();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  // One clock: expectation queued with the stimulus, compared mid-cycle.
  task automatic cycle(input logic es, input logic eb, input string tag);
    exp_t e;
    exp_t got;
    e.stall = es; e.bubble = eb; e.cnt = exp_cnt; e.cnt4 = exp_cnt4; e.tag = tag;
    exp_q.push_back(e);
    @(negedge clk);
    got = exp_q.pop_front();
    check({got.tag, ".stall"},   32'(if_main.stall),     32'(got.stall));
    check({got.tag, ".bubble"},  32'(if_main.bubble),    32'(got.bubble));
    check({got.tag, ".cnt"},     32'(if_main.stall_cnt), 32'(got.cnt));
    check({got.tag, ".stall4"},  32'(if_sat.stall),      32'(got.stall));
    check({got.tag, ".cnt4"},    32'(if_sat.stall_cnt),  32'(got.cnt4));
    if (es) begin
      if (exp_cnt  != 16'hFFFF) exp_cnt  = exp_cnt + 16'd1;
      if (exp_cnt4 != 4'hF)     exp_cnt4 = exp_cnt4 + 4'd1;
    end
    @(posedge clk);
    #1;
  endtask

  // Present the current instruction: n stall cycles, then it issues.
  task automatic dep(input int n, input string tag);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b1, {tag, "_stall"});
    cycle(1'b0, 1'b0, {tag, "_issue"});
  endtask

  task automatic drain(input string tag);
    idle_i();
    cycle(1'b0, 1'b0, tag);
    cycle(1'b0, 1'b0, tag);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    exp_cnt = '0; exp_cnt4 = '0;
    rst_n = 1'b0;
    idle_i();
    @(posedge clk);
    #1;

    // Reset state, with and without flush
    cycle(1'b0, 1'b0, "rst");
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, "rst_flush");
    idle_i();
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, "idle");

    // add $3,$1,$2 ; sub $4,$3,$5
    add_i(5'd3, 5'd1, 5'd2);  cycle(1'b0, 1'b0, "alu_prod");
    add_i(5'd4, 5'd3, 5'd5);  dep(FWD ? 0 : 2, "alu_use");
    drain("d1");

    // lw $3 ; add $4,$3,$1
    lw_i(5'd3, 5'd1);         cycle(1'b0, 1'b0, "ld_prod");
    add_i(5'd4, 5'd3, 5'd1);  dep(FWD ? 1 : 2, "ld_use");
    drain("d2");

    // lw $0 ; add $4,$0,$1
    lw_i(5'd0, 5'd1);         cycle(1'b0, 1'b0, "ld0_prod");
    add_i(5'd4, 5'd0, 5'd1);  dep(0, "ld0_use");
    drain("d3");

    // rt matches but is not read
    add_i(5'd3, 5'd1, 5'd2);  cycle(1'b0, 1'b0, "r2_prod");
    drive(1'b1, 1'b1, 1'b0, 5'd1, 5'd3, 1'b1, 5'd4, 1'b0, 1'b0);
    dep(0, "r2_unused");
    drain("d4");

    // producer with wr_en=0 naming $3
    drive(1'b1, 1'b1, 1'b1, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, "nowr_prod");
    add_i(5'd4, 5'd3, 5'd3);  dep(0, "nowr_use");
    drain("d5");

    // dependency only on MEM
    add_i(5'd3, 5'd1, 5'd2);  cycle(1'b0, 1'b0, "mem_prod");
    add_i(5'd6, 5'd1, 5'd2);  cycle(1'b0, 1'b0, "mem_gap");
    add_i(5'd4, 5'd3, 5'd5);  dep(FWD ? 0 : 1, "mem_use");
    drain("d6");

    // flush against a live hazard, then the same consumer unflushed
    lw_i(5'd3, 5'd1);         cycle(1'b0, 1'b0, "fl_prod");
    drive(1'b1, 1'b1, 1'b1, 5'd3, 5'd1, 1'b1, 5'd3, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, "fl_hazard");
    add_i(5'd3, 5'd3, 5'd1);  dep(FWD ? 0 : 1, "fl_after");
    drain("d7");
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, "fl_idle");
    drain("d8");

    // dependent load chain; drives the 4-bit counter into saturation
    lw_i(5'd3, 5'd3);         cycle(1'b0, 1'b0, "chain0");
    for (int i = 0; i < 15; i++) dep(FWD ? 1 : 2, "chain");
    drain("d9");

    // reset in the middle of a stall
    lw_i(5'd3, 5'd1);         cycle(1'b0, 1'b0, "rs_prod");
    add_i(5'd4, 5'd3, 5'd1);  cycle(1'b1, 1'b1, "rs_stall");
    rst_n = 1'b0;
    #1;
    check("rst_async.stall",  32'(if_main.stall),     32'd0);
    check("rst_async.bubble", 32'(if_main.bubble),    32'd0);
    check("rst_async.cnt",    32'(if_main.stall_cnt), 32'd0);
    check("rst_async.cnt4",   32'(if_sat.stall_cnt),  32'd0);
    exp_cnt = '0; exp_cnt4 = '0;
    #2;
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, "rs_release");
    drain("d10");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
